// File: rtl/uart_rx.sv
// uart_rx: 8-bit LSB-first UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined)
module uart_rx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk_50M,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_HIGH
    } state_t;

    state_t        state, state_d;
    logic          rx_m, rx_s;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          last, stop_hit, par_ok;

    assign last     = cnt == LAST;
    assign stop_hit = state == STOP && last;
    assign busy     = state != IDLE;

`ifdef UART_RX_PARITY_EN
    localparam state_t AFTER_DATA = PARITY;
    logic par_bit;
    assign par_ok = ~^{shreg, par_bit};
    // Capture the parity bit; flag frames whose stop is good but even parity fails
    always_ff @(posedge clk_50M) begin
        if (rst) begin
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            par_bit    <= (state == PARITY && last) ? rx_s : par_bit;
            parity_err <= stop_hit && rx_s && !par_ok;
        end
    end
`else
    localparam state_t AFTER_DATA = STOP;
    assign par_ok     = 1'b1;
    assign parity_err = 1'b0;
`endif

    // Two-flop synchroniser; idles high so reset never looks like a start bit
    always_ff @(posedge clk_50M) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    // State register
    always_ff @(posedge clk_50M) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    // Next state: start validated at mid-bit, later samples one bit period apart
    always_comb begin
        state_d = state;
        case (state)
            IDLE:      state_d = rx_s ? IDLE : START;
            START:     state_d = (cnt == HALF) ? (rx_s ? IDLE : DATA) : START;
            DATA:      state_d = (last && bit_idx == 3'd7) ? AFTER_DATA : DATA;
`ifdef UART_RX_PARITY_EN
            PARITY:    state_d = last ? STOP : PARITY;
`endif
            STOP:      state_d = last ? (rx_s ? IDLE : WAIT_HIGH) : STOP;
            WAIT_HIGH: state_d = rx_s ? IDLE : WAIT_HIGH;
            default:   state_d = IDLE;
        endcase
    end

    // Bit timing, LSB-first shift register and registered result strobes
    always_ff @(posedge clk_50M) begin
        if (rst) begin
            cnt       <= '0;
            bit_idx   <= 3'd0;
            shreg     <= 8'h00;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            cnt       <= (state_d != state || last) ? '0 : cnt + CW'(1);
            bit_idx   <= (state == DATA) ? bit_idx + 3'(last) : 3'd0;
            shreg     <= (state == DATA && last) ? {rx_s, shreg[7:1]} : shreg;
            rx_data   <= (stop_hit && rx_s && par_ok) ? shreg : rx_data;
            rx_valid  <= stop_hit && rx_s && par_ok;
            frame_err <= stop_hit && !rx_s;
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames with a queue-based scoreboard checking strobe kind, byte and timing
module tb_uart_rx;
    localparam int BIT = 434;
`ifdef UART_RX_PARITY_EN
    localparam int LAT = 4560;
`else
    localparam int LAT = 4126;
`endif

    typedef struct {
        int         kind;
        logic [7:0] data;
        int         t;
    } exp_t;

    logic       clk_50M, rst, rx;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, parity_err, busy;
    int         cyc = 0;
    int         vectors = 0;
    int         miscompares = 0;
    exp_t       q[$];
    logic [7:0] last_good;

    uart_rx #(.CLKS_PER_BIT(BIT)) dut (
        .clk_50M   (clk_50M),
        .rst       (rst),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .parity_err(parity_err),
        .busy      (busy)
    );

    initial clk_50M = 1'b0;
    always #10 clk_50M = ~clk_50M;
    always @(posedge clk_50M) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // kind: 0 = rx_valid, 1 = frame_err, 2 = parity_err; exp = rx_data expected at the strobe
    task automatic send(input logic [7:0] d, input logic stop, input logic bad_par,
                        input int kind, input logic [7:0] exp);
        q.push_back('{kind, exp, cyc + LAT});
        rx = 1'b0;
        repeat (BIT) @(negedge clk_50M);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (BIT) @(negedge clk_50M);
        end
`ifdef UART_RX_PARITY_EN
        rx = ^d ^ bad_par;
        repeat (BIT) @(negedge clk_50M);
`endif
        rx = stop;
        repeat (BIT) @(negedge clk_50M);
    endtask

    // Monitor: every strobe must match the oldest pending expectation
    initial begin
        exp_t e;
        int   kind;
        forever begin
            @(negedge clk_50M);
            if (!rst && (rx_valid || frame_err || parity_err)) begin
                vectors++;
                if (int'(rx_valid) + int'(frame_err) + int'(parity_err) > 1) begin
                    miscompares++;
                    $display("FAIL strobe_overlap: got v=%b f=%b p=%b expected a single strobe",
                             rx_valid, frame_err, parity_err);
                end else if (q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_strobe: got v=%b f=%b p=%b data=0x%02h at %0d expected none",
                             rx_valid, frame_err, parity_err, rx_data, cyc);
                end else begin
                    e = q.pop_front();
                    kind = rx_valid ? 0 : frame_err ? 1 : 2;
                    if (kind != e.kind || rx_data !== e.data || cyc > e.t + 3 || cyc < e.t - 3) begin
                        miscompares++;
                        $display("FAIL frame: got kind=%0d data=0x%02h cycle=%0d expected kind=%0d data=0x%02h cycle=%0d+-3",
                                 kind, rx_data, cyc, e.kind, e.data, e.t);
                    end
                end
            end
        end
    end

    // Stimulus
    initial begin
        logic [7:0] d;
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk_50M);
        chk("reset_rx_data", rx_data, 8'h00);
        chk("reset_rx_valid", rx_valid, 0);
        chk("reset_frame_err", frame_err, 0);
        chk("reset_parity_err", parity_err, 0);
        chk("reset_busy", busy, 0);
        rst = 1'b0;
        repeat (10) @(negedge clk_50M);

        send(8'h55, 1'b1, 1'b0, 0, 8'h55);
        last_good = 8'h55;
        repeat (10) @(negedge clk_50M);
        chk("idle_after_55", busy, 0);

        rx = 1'b0;
        repeat (100) @(negedge clk_50M);
        chk("glitch_busy_high", busy, 1);
        rx = 1'b1;
        repeat (125) @(negedge clk_50M);
        chk("glitch_busy_low", busy, 0);
        chk("glitch_rx_data", rx_data, last_good);

        send(8'h3C, 1'b1, 1'b0, 0, 8'h3C);
        last_good = 8'h3C;
        repeat (10) @(negedge clk_50M);
        send(8'hA3, 1'b0, 1'b0, 1, last_good);
        rx = 1'b0;
        repeat (2000) @(negedge clk_50M);
        chk("break_busy", busy, 1);
        rx = 1'b1;
        repeat (20) @(negedge clk_50M);
        chk("break_rx_data", rx_data, 8'h3C);
        send(8'h0F, 1'b1, 1'b0, 0, 8'h0F);
        repeat (10) @(negedge clk_50M);

        send(8'h00, 1'b1, 1'b0, 0, 8'h00);
        send(8'hFF, 1'b1, 1'b0, 0, 8'hFF);
        send(8'h81, 1'b1, 1'b0, 0, 8'h81);
        repeat (10) @(negedge clk_50M);

        d  = 8'h5A;
        rx = 1'b0;
        repeat (BIT) @(negedge clk_50M);
        for (int i = 0; i < 4; i++) begin
            rx = d[i];
            repeat (BIT) @(negedge clk_50M);
        end
        rx = d[4];
        repeat (200) @(negedge clk_50M);
        chk("midframe_busy", busy, 1);
        rst = 1'b1;
        rx  = 1'b1;
        @(negedge clk_50M);
        chk("midrst_rx_data", rx_data, 8'h00);
        chk("midrst_rx_valid", rx_valid, 0);
        chk("midrst_frame_err", frame_err, 0);
        chk("midrst_parity_err", parity_err, 0);
        chk("midrst_busy", busy, 0);
        rst = 1'b0;
        repeat (20) @(negedge clk_50M);
        send(8'hC3, 1'b1, 1'b0, 0, 8'hC3);

`ifdef UART_RX_PARITY_EN
        repeat (10) @(negedge clk_50M);
        send(8'h07, 1'b1, 1'b0, 0, 8'h07);
        repeat (10) @(negedge clk_50M);
        send(8'h07, 1'b1, 1'b1, 2, 8'h07);
`endif

        repeat (50) @(negedge clk_50M);
        chk("pending_expectations", q.size(), 0);
        chk("final_busy", busy, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
# uart_rx

Serial UART receiver on the 50 MHz board clock, counterpart to the team's `uart` transmitter: 8 data bits, LSB first, 1 stop bit, 115200 baud (434 clocks/bit). Asynchronous `rx` line is synchronised, start bit is validated at mid-bit, data is sampled at bit centres, and each frame produces either a one-cycle `rx_valid` strobe with the byte or a one-cycle error strobe. Sits between the board UART pin and any byte-consuming logic (command decoder, loopback checker against `uart`).

## Interface
- `CLKS_PER_BIT`, 434, clock cycles per bit (50 MHz / 115200); legal range 4..65535.
- `clk_50M`  input  1  50 MHz clock; all logic on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `rx`  input  1  asynchronous serial input; idle high.
- `rx_data`  output  8  last correctly received byte; updated only on a good frame.
- `rx_valid`  output  1  one-cycle pulse: `rx_data` just updated.
- `frame_err`  output  1  one-cycle pulse: stop bit sampled low.
- `parity_err`  output  1  one-cycle pulse: parity mismatch (constant 0 without macro).
- `busy`  output  1  high whenever state is not IDLE.

## Operation
- Input: 2-flop synchroniser on `rx`, both flops reset to 1; FSM sees only synchronised `rx_s`.
- Bit counter `cnt`, width $clog2(CLKS_PER_BIT); zeroed on every state change; `HALF = (CLKS_PER_BIT-1)/2` (216 by default).
- States and transitions:
  - IDLE: `rx_s==0` -> START.
  - START: at `cnt==HALF` sample; `rx_s==0` -> DATA (bit index 0); `rx_s==1` -> IDLE, no output (glitch reject).
  - DATA: at `cnt==CLKS_PER_BIT-1` shift `rx_s` into shift register MSB (LSB-first reception); after bit index 7 -> PARITY (macro) or STOP.
  - PARITY (macro only): at `cnt==CLKS_PER_BIT-1` sample and store parity bit -> STOP.
  - STOP: at `cnt==CLKS_PER_BIT-1` sample. High and parity OK -> load `rx_data`, pulse `rx_valid`, -> IDLE. High and parity bad -> pulse `parity_err`, -> IDLE. Low -> pulse `frame_err`, -> WAIT_HIGH.
  - WAIT_HIGH: stay until `rx_s==1` -> IDLE (break/line-low recovery; no repeated error pulses).
- Exactly one of `rx_valid`/`frame_err`/`parity_err` per completed frame; never two in one cycle. Stop-low takes precedence over parity.
- `rx_data` holds value across errors and glitches.

## Timing
- Reset values: `rx_data`=0x00, `rx_valid`=0, `frame_err`=0, `parity_err`=0, `busy`=0, FSM=IDLE, synchroniser=1.
- Reset mid-frame: abort, return to reset values next cycle, no strobe.
- `rx` to `rx_s`: 2 cycles. START entered the cycle after `rx_s` falls.
- Sample points after START entry: start at +HALF, data bit n at +HALF+1+(n+1)*CLKS_PER_BIT-1 ... i.e. consecutive bit centres spaced exactly CLKS_PER_BIT cycles.
- Strobe asserted in the cycle after the stop-bit sample (registered output); default config: ~9.5 bit times (≈4126 cycles) after the `rx` falling edge, bench tolerance ±3 cycles.
- Returns to IDLE immediately after a good stop sample (mid-stop-bit), so a back-to-back start bit is never missed.
- `busy` goes high the cycle START is entered, low the cycle IDLE is re-entered.

## Configuration
- `UART_RX_PARITY_EN` defined: frame is start + 8 data + even parity + stop; PARITY state present; `parity_err` driven as above (even parity: XOR of 8 data bits and parity bit must be 0).
- Undefined: 8N1 frame, no PARITY state, `parity_err` tied 0; port list unchanged.

## Test plan
- Drive 0x55 as 8N1 at 434 clk/bit -> exactly one `rx_valid` pulse, `rx_data`=0x55, `busy` low afterwards, no error strobes.
- `rx` low for 100 cycles then high -> no strobes, `busy` high then back to 0 within 220 cycles, `rx_data` unchanged.
- After receiving 0x3C, send 0xA3 with stop bit low, hold `rx` low 2000 cycles, then send 0x0F -> single `frame_err` pulse, `rx_data` stays 0x3C, then `rx_valid` with 0x0F.
- Back-to-back 0x00, 0xFF, 0x81 with one stop bit each, no idle gap -> three `rx_valid` pulses in order, spacing 10×434 ±2 cycles.
- Assert `rst` for 1 cycle during data bit 4 of 0x5A, then send 0xC3 -> all outputs at reset values next cycle, then `rx_valid` with 0xC3.
- With `UART_RX_PARITY_EN`: 0x07 with parity 1 -> `rx_valid`, 0x07; 0x07 with parity 0 -> `parity_err` pulse only, `rx_data` unchanged.
